// File: rtl/fetch_addr_queue_pkg.sv
// Fetch address queue: entry/state types, default geometry and the
// helper that splits a fetch request at an ICache block boundary.
package fetch_addr_queue_pkg;

    localparam int unsigned FAQ_VALEN       = 32;
    localparam int unsigned FAQ_FETCH_WIDTH = 4;
    localparam int unsigned FAQ_BLOCK_WORDS = 16;
    localparam int unsigned FAQ_WIDX_W      = $clog2(FAQ_BLOCK_WORDS);
    localparam int unsigned FAQ_OFF_W       = FAQ_WIDX_W + 2;

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } faq_state_e;

    typedef struct packed {
        logic [FAQ_VALEN-1:0]       vaddr;
        logic [FAQ_FETCH_WIDTH-1:0] mask;
        logic                       tail;
    } faq_entry_t;

    typedef struct packed {
        faq_entry_t head;
        faq_entry_t tail;
    } faq_split_t;

    // Slots past the block end shift down into the next block's entry.
    function automatic faq_split_t faq_split(
        input logic [FAQ_VALEN-1:0]       vaddr,
        input logic [FAQ_FETCH_WIDTH-1:0] mask
    );
        faq_split_t                 s;
        logic [FAQ_WIDX_W:0]        room;
        logic [FAQ_FETCH_WIDTH-1:0] keep;
        logic [FAQ_VALEN-1:0]       base;
        room = (FAQ_WIDX_W+1)'(FAQ_BLOCK_WORDS)
             - {1'b0, vaddr[2 +: FAQ_WIDX_W]};
        keep = ~({FAQ_FETCH_WIDTH{1'b1}} << room);
        base = {vaddr[FAQ_VALEN-1:FAQ_OFF_W], {FAQ_OFF_W{1'b0}}};
        s.head.vaddr = vaddr;
        s.head.mask  = mask & keep;
        s.head.tail  = 1'b0;
        s.tail.vaddr = base + FAQ_VALEN'(4 * FAQ_BLOCK_WORDS);
        s.tail.mask  = mask >> room;
        s.tail.tail  = 1'b1;
        return s;
    endfunction

endpackage

// File: rtl/faq_dual_push_fifo.sv
// Register FIFO with up to two in-order writes and one read per cycle;
// the head entry is read straight out of the storage registers.
module faq_dual_push_fifo
    import fetch_addr_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush_i,
    input  logic       wr0_i,
    input  faq_entry_t wr0_data_i,
    input  logic       wr1_i,
    input  faq_entry_t wr1_data_i,
    input  logic       rd_i,
    output logic       rd_valid_o,
    output faq_entry_t rd_data_o,
    output logic [AW:0] usage_o
);

    faq_entry_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   usage_q;
    logic [AW:0]   n_wr;
    logic          rd_fire;

    assign rd_fire = rd_i & (usage_q != '0);
    assign n_wr    = (AW+1)'(wr0_i) + (AW+1)'(wr1_i);

    // wr1 is only ever used together with wr0, in the slot after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usage_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usage_q  <= '0;
        end else begin
            if (wr0_i) begin
                mem_q[wr_ptr_q] <= wr0_data_i;
            end
            if (wr1_i) begin
                mem_q[wr_ptr_q + AW'(1)] <= wr1_data_i;
            end
            wr_ptr_q <= wr_ptr_q + n_wr[AW-1:0];
            if (rd_fire) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            usage_q <= usage_q + n_wr - (AW+1)'(rd_fire);
        end
    end

    assign rd_valid_o = usage_q != '0;
    assign rd_data_o  = mem_q[rd_ptr_q];
    assign usage_o    = usage_q;

endmodule

// File: rtl/fetch_addr_queue.sv
// Fetch address queue: splits block-crossing fetch requests into
// head/tail entries and buffers them for the ICache fetch stage.
module fetch_addr_queue
    import fetch_addr_queue_pkg::*;
#(
    parameter int unsigned VALEN       = FAQ_VALEN,
    parameter int unsigned FETCH_WIDTH = FAQ_FETCH_WIDTH,
    parameter int unsigned BLOCK_WORDS = FAQ_BLOCK_WORDS,
    parameter int unsigned DEPTH       = 8,
    localparam int unsigned UW         = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   push_valid_i,
    output logic                   push_ready_o,
    input  logic [VALEN-1:0]       push_vaddr_i,
    input  logic [FETCH_WIDTH-1:0] push_mask_i,
    output logic                   pop_valid_o,
    input  logic                   pop_ready_i,
    output logic [VALEN-1:0]       pop_vaddr_o,
    output logic [FETCH_WIDTH-1:0] pop_mask_o,
    output logic                   pop_tail_o,
    output logic [UW-1:0]          usage_o
);

    // Entry layout and split helper are sized by the package geometry.
    if (VALEN != FAQ_VALEN || FETCH_WIDTH != FAQ_FETCH_WIDTH
        || BLOCK_WORDS != FAQ_BLOCK_WORDS) begin : g_bad_cfg
        $error("fetch_addr_queue geometry differs from package");
    end

    faq_state_e state_q;
    faq_entry_t held_q;
    faq_split_t sp;
    faq_entry_t wr0_d;
    faq_entry_t wr1_d;
    faq_entry_t rd_d;
    logic       wr0_v;
    logic       wr1_v;
    logic       go_hold;
    logic       accept;
    logic       hold_st;
    logic       has_free;
    logic       has_two;
    logic       head_ne;
    logic       tail_ne;
    logic       rd_v;
    logic [UW-1:0] usage;

    assign sp       = faq_split(push_vaddr_i, push_mask_i);
    assign head_ne  = |sp.head.mask;
    assign tail_ne  = |sp.tail.mask;
    assign has_free = usage != UW'(DEPTH);
    assign has_two  = usage <= UW'(DEPTH - 2);
    assign hold_st  = state_q == S_HOLD;

    assign push_ready_o = (state_q == S_IDLE) & has_free;
    assign accept       = push_valid_i & push_ready_o & ~flush_i;

    always_comb begin
        wr0_v   = 1'b0;
        wr1_v   = 1'b0;
        wr0_d   = sp.head;
        wr1_d   = sp.tail;
        go_hold = 1'b0;
        unique case (1'b1)
            hold_st: begin
                wr0_v = has_free;
                wr0_d = held_q;
            end
            accept && head_ne && tail_ne: begin
                wr0_v   = 1'b1;
                wr1_v   = has_two;
                go_hold = !has_two;
            end
            accept && head_ne && !tail_ne: begin
                wr0_v = 1'b1;
            end
            accept && !head_ne && tail_ne: begin
                wr0_v = 1'b1;
                wr0_d = sp.tail;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            held_q  <= '0;
        end else if (flush_i) begin
            state_q <= S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (go_hold) begin
                        state_q <= S_HOLD;
                        held_q  <= sp.tail;
                    end
                end
                S_HOLD: begin
                    if (has_free) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    faq_dual_push_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (flush_i),
        .wr0_i     (wr0_v),
        .wr0_data_i(wr0_d),
        .wr1_i     (wr1_v),
        .wr1_data_i(wr1_d),
        .rd_i      (pop_ready_i),
        .rd_valid_o(rd_v),
        .rd_data_o (rd_d),
        .usage_o   (usage)
    );

    assign pop_valid_o = rd_v;
    assign pop_vaddr_o = rd_d.vaddr;
    assign pop_mask_o  = rd_d.mask;
    assign pop_tail_o  = rd_d.tail;
    assign usage_o     = usage;

endmodule

// File: tb/tb_fetch_addr_queue.sv
// Directed bench for fetch_addr_queue: split, hold, wrap, flush
// and simultaneous push/pop scenarios with hand-computed entries.
module tb_fetch_addr_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic        push_valid_i;
    logic        push_ready_o;
    logic [31:0] push_vaddr_i;
    logic [3:0]  push_mask_i;
    logic        pop_valid_o;
    logic        pop_ready_i;
    logic [31:0] pop_vaddr_o;
    logic [3:0]  pop_mask_o;
    logic        pop_tail_o;
    logic [3:0]  usage_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_addr_queue #(
        .VALEN(32), .FETCH_WIDTH(4), .BLOCK_WORDS(16), .DEPTH(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .push_valid_i(push_valid_i),
        .push_ready_o(push_ready_o),
        .push_vaddr_i(push_vaddr_i),
        .push_mask_i (push_mask_i),
        .pop_valid_o (pop_valid_o),
        .pop_ready_i (pop_ready_i),
        .pop_vaddr_o (pop_vaddr_o),
        .pop_mask_o  (pop_mask_o),
        .pop_tail_o  (pop_tail_o),
        .usage_o     (usage_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a,
                         input logic [3:0] m, input logic pr);
        push_valid_i = v;
        push_vaddr_i = a;
        push_mask_i  = m;
        pop_ready_i  = pr;
    endtask

    task automatic fill7();
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 32'h2000 + 32'(k * 16), 4'hF, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush_i = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 1'b0);
        #12;
        n_checks++;
        if ({usage_o, pop_valid_o, push_ready_o} !== {4'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_ctl: got u=%0d pv=%b pr=%b need u=0 pv=0 pr=1",
                     usage_o, pop_valid_o, push_ready_o);
        end
        n_checks++;
        if ({pop_vaddr_o, pop_mask_o, pop_tail_o} !== 37'h0) begin
            n_fail++;
            $display("FAIL reset_pop: got %h/%b/%b need 0/0000/0",
                     pop_vaddr_o, pop_mask_o, pop_tail_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_no_split();
        drive(1'b1, 32'h1000, 4'hF, 1'b1);
        tick();
        n_checks++;
        if ({usage_o, pop_valid_o, pop_vaddr_o, pop_mask_o, pop_tail_o}
            !== {4'd1, 1'b1, 32'h1000, 4'hF, 1'b0}) begin
            n_fail++;
            $display("FAIL no_split: got u=%0d %b %h/%b/%b need u=1 1 1000/1111/0",
                     usage_o, pop_valid_o, pop_vaddr_o, pop_mask_o, pop_tail_o);
        end
        drive(1'b0, 32'h0, 4'h0, 1'b1);
        tick();
        n_checks++;
        if ({usage_o, pop_valid_o} !== {4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL no_split_drain: got u=%0d pv=%b need u=0 pv=0",
                     usage_o, pop_valid_o);
        end
    endtask

    task automatic test_split_room();
        drive(1'b1, 32'h1038, 4'hF, 1'b0);
        tick();
        n_checks++;
        if ({usage_o, push_ready_o, pop_vaddr_o, pop_mask_o, pop_tail_o}
            !== {4'd2, 1'b1, 32'h1038, 4'b0011, 1'b0}) begin
            n_fail++;
            $display("FAIL split_head: got u=%0d pr=%b %h/%b/%b need u=2 pr=1 1038/0011/0",
                     usage_o, push_ready_o, pop_vaddr_o, pop_mask_o, pop_tail_o);
        end
        drive(1'b0, 32'h0, 4'h0, 1'b1);
        tick();
        n_checks++;
        if ({usage_o, pop_vaddr_o, pop_mask_o, pop_tail_o}
            !== {4'd1, 32'h1040, 4'b0011, 1'b1}) begin
            n_fail++;
            $display("FAIL split_tail: got u=%0d %h/%b/%b need u=1 1040/0011/1",
                     usage_o, pop_vaddr_o, pop_mask_o, pop_tail_o);
        end
        tick();
    endtask

    task automatic test_split_one_free();
        fill7();
        n_checks++;
        if ({usage_o, push_ready_o} !== {4'd7, 1'b1}) begin
            n_fail++;
            $display("FAIL fill7: got u=%0d pr=%b need u=7 pr=1",
                     usage_o, push_ready_o);
        end
        drive(1'b1, 32'h103C, 4'hF, 1'b0);
        tick();
        drive(1'b0, 32'h0, 4'h0, 1'b0);
        tick();
        n_checks++;
        if ({usage_o, push_ready_o} !== {4'd8, 1'b0}) begin
            n_fail++;
            $display("FAIL hold_enter: got u=%0d pr=%b need u=8 pr=0",
                     usage_o, push_ready_o);
        end
        pop_ready_i = 1'b1;
        tick();
        n_checks++;
        if ({usage_o, push_ready_o, pop_vaddr_o} !== {4'd7, 1'b0, 32'h2010}) begin
            n_fail++;
            $display("FAIL hold_full_pop: got u=%0d pr=%b %h need u=7 pr=0 2010",
                     usage_o, push_ready_o, pop_vaddr_o);
        end
        tick();
        n_checks++;
        if ({usage_o, push_ready_o, pop_vaddr_o} !== {4'd7, 1'b1, 32'h2020}) begin
            n_fail++;
            $display("FAIL hold_exit: got u=%0d pr=%b %h need u=7 pr=1 2020",
                     usage_o, push_ready_o, pop_vaddr_o);
        end
        for (int k = 0; k < 5; k++) tick();
        n_checks++;
        if ({pop_vaddr_o, pop_mask_o, pop_tail_o} !== {32'h103C, 4'b0001, 1'b0}) begin
            n_fail++;
            $display("FAIL hold_head: got %h/%b/%b need 103c/0001/0",
                     pop_vaddr_o, pop_mask_o, pop_tail_o);
        end
        tick();
        n_checks++;
        if ({pop_vaddr_o, pop_mask_o, pop_tail_o} !== {32'h1040, 4'b0111, 1'b1}) begin
            n_fail++;
            $display("FAIL hold_tail: got %h/%b/%b need 1040/0111/1",
                     pop_vaddr_o, pop_mask_o, pop_tail_o);
        end
        tick();
        n_checks++;
        if ({usage_o, pop_valid_o} !== {4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL hold_drain: got u=%0d pv=%b need u=0 pv=0",
                     usage_o, pop_valid_o);
        end
    endtask

    task automatic test_head_empty();
        drive(1'b1, 32'h1038, 4'b1100, 1'b0);
        tick();
        n_checks++;
        if ({usage_o, pop_vaddr_o, pop_mask_o, pop_tail_o}
            !== {4'd1, 32'h1040, 4'b0011, 1'b1}) begin
            n_fail++;
            $display("FAIL head_empty: got u=%0d %h/%b/%b need u=1 1040/0011/1",
                     usage_o, pop_vaddr_o, pop_mask_o, pop_tail_o);
        end
        drive(1'b0, 32'h0, 4'h0, 1'b1);
        tick();
    endtask

    task automatic test_wrap();
        drive(1'b1, 32'hFFFF_FFF8, 4'hF, 1'b0);
        tick();
        n_checks++;
        if ({usage_o, pop_vaddr_o, pop_mask_o, pop_tail_o}
            !== {4'd2, 32'hFFFF_FFF8, 4'b0011, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_head: got u=%0d %h/%b/%b need u=2 fffffff8/0011/0",
                     usage_o, pop_vaddr_o, pop_mask_o, pop_tail_o);
        end
        drive(1'b0, 32'h0, 4'h0, 1'b1);
        tick();
        n_checks++;
        if ({pop_vaddr_o, pop_mask_o, pop_tail_o} !== {32'h0, 4'b0011, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap_tail: got %h/%b/%b need 00000000/0011/1",
                     pop_vaddr_o, pop_mask_o, pop_tail_o);
        end
        tick();
    endtask

    task automatic test_zero_mask();
        drive(1'b1, 32'h1038, 4'b0000, 1'b0);
        tick();
        drive(1'b0, 32'h0, 4'h0, 1'b0);
        n_checks++;
        if ({usage_o, pop_valid_o, push_ready_o} !== {4'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL zero_mask: got u=%0d pv=%b pr=%b need u=0 pv=0 pr=1",
                     usage_o, pop_valid_o, push_ready_o);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'h3000, 4'hF, 1'b1);
        tick();
        drive(1'b1, 32'h3010, 4'hF, 1'b1);
        tick();
        n_checks++;
        if ({usage_o, pop_vaddr_o} !== {4'd1, 32'h3010}) begin
            n_fail++;
            $display("FAIL b2b_pushpop: got u=%0d %h need u=1 3010",
                     usage_o, pop_vaddr_o);
        end
        drive(1'b1, 32'h1038, 4'hF, 1'b1);
        tick();
        n_checks++;
        if ({usage_o, pop_vaddr_o, pop_mask_o, pop_tail_o}
            !== {4'd2, 32'h1038, 4'b0011, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_split_pop: got u=%0d %h/%b/%b need u=2 1038/0011/0",
                     usage_o, pop_vaddr_o, pop_mask_o, pop_tail_o);
        end
        drive(1'b0, 32'h0, 4'h0, 1'b1);
        tick();
        tick();
        n_checks++;
        if (usage_o !== 4'd0) begin
            n_fail++;
            $display("FAIL b2b_drain: got u=%0d need u=0", usage_o);
        end
    endtask

    task automatic test_flush();
        fill7();
        drive(1'b1, 32'h103C, 4'hF, 1'b0);
        tick();
        flush_i = 1'b1;
        drive(1'b1, 32'h5000, 4'hF, 1'b1);
        tick();
        n_checks++;
        if ({usage_o, pop_valid_o, push_ready_o} !== {4'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL flush_hold: got u=%0d pv=%b pr=%b need u=0 pv=0 pr=1",
                     usage_o, pop_valid_o, push_ready_o);
        end
        n_checks++;
        if (push_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_ready: got pr=%b need pr=1", push_ready_o);
        end
        tick();
        n_checks++;
        if ({usage_o, pop_valid_o} !== {4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_idle_push: got u=%0d pv=%b need u=0 pv=0",
                     usage_o, pop_valid_o);
        end
        flush_i = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 1'b0);
        tick();
        tick();
        n_checks++;
        if ({usage_o, pop_valid_o} !== {4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_no_tail: got u=%0d pv=%b need u=0 pv=0",
                     usage_o, pop_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_no_split();
        test_split_room();
        test_split_one_free();
        test_head_empty();
        test_wrap();
        test_zero_mask();
        test_back_to_back();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
